// File: rtl/ob_pkg.sv
// ============================================================================
// Module      : ob_pkg
// Description : Shared order-book command type and opcode encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ob_pkg;

    typedef logic [3:0] op_t;

    localparam op_t OP_NOP             = 4'd0;
    localparam op_t OP_BUY_LIMIT       = 4'd1;
    localparam op_t OP_SELL_LIMIT      = 4'd2;
    localparam op_t OP_BUY_MARKET      = 4'd3;
    localparam op_t OP_SELL_MARKET     = 4'd4;
    localparam op_t OP_CANCEL          = 4'd5;
    localparam op_t OP_BUY_STOP_LIMIT  = 4'd6;
    localparam op_t OP_SELL_STOP_LIMIT = 4'd7;
    localparam op_t OP_BUY_STOP_LOSS   = 4'd8;
    localparam op_t OP_SELL_STOP_LOSS  = 4'd9;

    typedef struct packed {
        op_t         opcode;
        logic [15:0] uid;
        logic [31:0] price;
        logic [31:0] quantity;
    } cmd_t;

endpackage

`default_nettype wire

// File: rtl/ob_cn_reissue.sv
// ============================================================================
// Module      : ob_cn_reissue
// Description : Rewrites matured stop commands to executable form and merges
//               them, with priority and a burst limit, into the ingress stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ob_cn_reissue
    import ob_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mtr_vld_r,
    input  cmd_t             mtr_r,
    output logic             mtr_accept,
    input  logic             in_vld,
    input  cmd_t             in_cmd,
    output logic             in_accept,
    output logic             out_vld_r,
    output cmd_t             out_cmd_r,
    output logic             out_src_r,
    input  logic             out_accept,
    output logic [CNT_W-1:0] reissue_cnt_r,
    output logic             err_r
);

    localparam int                   c_BURST_W   = $clog2(MAX_BURST + 1);
    localparam logic [c_BURST_W-1:0] c_MAX_BURST = c_BURST_W'(MAX_BURST);

    logic [c_BURST_W-1:0] r_burst_cnt;
    logic                 w_slot_free;
    logic                 w_mtr_go;
    logic                 w_in_go;
    cmd_t                 w_mtr_cmd;
    logic                 w_bad_op;

    assign w_slot_free = !out_vld_r || out_accept;

    // Accepts are gated by rst_n so nothing is consumed while reset is held.
    assign w_mtr_go   = rst_n && w_slot_free && mtr_vld_r
                        && (!in_vld || (r_burst_cnt < c_MAX_BURST));
    assign w_in_go    = rst_n && w_slot_free && !w_mtr_go && in_vld;
    assign mtr_accept = w_mtr_go;
    assign in_accept  = w_in_go;

    always_comb begin
        w_mtr_cmd = mtr_r;
        w_bad_op  = 1'b0;
        case (mtr_r.opcode)
            OP_BUY_STOP_LIMIT:  w_mtr_cmd.opcode = OP_BUY_LIMIT;
            OP_SELL_STOP_LIMIT: w_mtr_cmd.opcode = OP_SELL_LIMIT;
            OP_BUY_STOP_LOSS:   w_mtr_cmd.opcode = OP_BUY_MARKET;
            OP_SELL_STOP_LOSS:  w_mtr_cmd.opcode = OP_SELL_MARKET;
            default:            w_bad_op         = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_r <= 1'b0;
            out_cmd_r <= '0;
            out_src_r <= 1'b0;
        end else if (w_mtr_go) begin
            out_vld_r <= 1'b1;
            out_cmd_r <= w_mtr_cmd;
            out_src_r <= 1'b1;
        end else if (w_in_go) begin
            out_vld_r <= 1'b1;
            out_cmd_r <= in_cmd;
            out_src_r <= 1'b0;
        end else if (out_accept) begin
            out_vld_r <= 1'b0;
        end
    end

    // Burst count only grows while ingress is actually waiting behind matured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_burst_cnt <= '0;
        end else if (!in_vld || w_in_go) begin
            r_burst_cnt <= '0;
        end else if (w_mtr_go && (r_burst_cnt < c_MAX_BURST)) begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reissue_cnt_r <= '0;
            err_r         <= 1'b0;
        end else if (w_mtr_go) begin
            reissue_cnt_r <= reissue_cnt_r + 1'b1;
            if (w_bad_op) begin
                err_r <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ob_cn_reissue.sv
// ============================================================================
// Module      : tb_ob_cn_reissue
// Description : Self-checking bench: directed scenarios plus randomized
//               traffic compared against a cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ob_cn_reissue;
    import ob_pkg::*;

    localparam int MB = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mtr_vld_r = 1'b0;
    cmd_t          mtr_r = '0;
    logic          mtr_accept;
    logic          in_vld = 1'b0;
    cmd_t          in_cmd = '0;
    logic          in_accept;
    logic          out_vld_r;
    cmd_t          out_cmd_r;
    logic          out_src_r;
    logic          out_accept = 1'b0;
    logic [CW-1:0] reissue_cnt_r;
    logic          err_r;

    int checks   = 0;
    int failures = 0;

    ob_cn_reissue #(.MAX_BURST(MB), .CNT_W(CW)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mtr_vld_r     (mtr_vld_r),
        .mtr_r         (mtr_r),
        .mtr_accept    (mtr_accept),
        .in_vld        (in_vld),
        .in_cmd        (in_cmd),
        .in_accept     (in_accept),
        .out_vld_r     (out_vld_r),
        .out_cmd_r     (out_cmd_r),
        .out_src_r     (out_src_r),
        .out_accept    (out_accept),
        .reissue_cnt_r (reissue_cnt_r),
        .err_r         (err_r)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic cmd_t mk_cmd(input op_t op, input int uid, input int price, input int qty);
        cmd_t c;
        c.opcode   = op;
        c.uid      = 16'(uid);
        c.price    = 32'(price);
        c.quantity = 32'(qty);
        return c;
    endfunction

    function automatic bit is_stop(input op_t op);
        return (op == OP_BUY_STOP_LIMIT) || (op == OP_SELL_STOP_LIMIT) ||
               (op == OP_BUY_STOP_LOSS)  || (op == OP_SELL_STOP_LOSS);
    endfunction

    function automatic cmd_t exec_form(input cmd_t c);
        cmd_t r = c;
        if (c.opcode == OP_BUY_STOP_LIMIT)  r.opcode = OP_BUY_LIMIT;
        if (c.opcode == OP_SELL_STOP_LIMIT) r.opcode = OP_SELL_LIMIT;
        if (c.opcode == OP_BUY_STOP_LOSS)   r.opcode = OP_BUY_MARKET;
        if (c.opcode == OP_SELL_STOP_LOSS)  r.opcode = OP_SELL_MARKET;
        return r;
    endfunction

    function automatic cmd_t rand_mtr();
        op_t op;
        if ($urandom_range(19) == 0) op = op_t'($urandom_range(9));
        else                         op = op_t'(6 + $urandom_range(3));
        return mk_cmd(op, $urandom, $urandom, $urandom);
    endfunction

    // Leaves the bench just after a negedge with reset released.
    task automatic do_reset();
        rst_n      = 1'b0;
        mtr_vld_r  = 1'b0;
        in_vld     = 1'b0;
        out_accept = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference model state
    bit            e_vld;
    cmd_t          e_cmd;
    bit            e_src;
    logic [CW-1:0] e_cnt;
    bit            e_err;
    int            e_burst;

    initial begin
        cmd_t c_a, c_b, c_i;
        bit   slot, m_go, i_go, prev_m_go, prev_i_go;

        // Basic matured reissue
        do_reset();
        #1;
        check("rst_out_vld", out_vld_r, 0);
        check("rst_out_cmd", out_cmd_r, 0);
        check("rst_out_src", out_src_r, 0);
        check("rst_cnt", reissue_cnt_r, 0);
        check("rst_err", err_r, 0);
        c_a = mk_cmd(OP_BUY_STOP_LIMIT, 'h12, 100, 7);
        mtr_vld_r  = 1'b1;
        mtr_r      = c_a;
        out_accept = 1'b1;
        #1;
        check("basic_mtr_acc", mtr_accept, 1);
        check("basic_in_acc", in_accept, 0);
        @(negedge clk);
        mtr_vld_r = 1'b0;
        #1;
        check("basic_vld", out_vld_r, 1);
        check("basic_op", out_cmd_r.opcode, OP_BUY_LIMIT);
        check("basic_uid", out_cmd_r.uid, 'h12);
        check("basic_price", out_cmd_r.price, 100);
        check("basic_src", out_src_r, 1);
        check("basic_cnt", reissue_cnt_r, 1);

        // Burst limiter: M,M,M,M,I repeating
        c_b = mk_cmd(OP_SELL_STOP_LOSS, 'h34, 200, 9);
        c_i = mk_cmd(OP_CANCEL, 'h56, 300, 11);
        mtr_vld_r = 1'b1;
        mtr_r     = c_b;
        in_vld    = 1'b1;
        in_cmd    = c_i;
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("burst_in_acc%0d", i), in_accept, (i % 5) == 4);
            check($sformatf("burst_mtr_acc%0d", i), mtr_accept, (i % 5) != 4);
            @(negedge clk);
        end

        // Downstream stall holds everything, then resumes without a bubble
        out_accept = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_mtr_acc", mtr_accept, 0);
            check("stall_in_acc", in_accept, 0);
            check("stall_cmd", out_cmd_r, c_i);
            check("stall_vld", out_vld_r, 1);
            @(negedge clk);
        end
        out_accept = 1'b1;
        #1;
        check("resume_mtr_acc", mtr_accept, 1);
        @(negedge clk);
        in_vld = 1'b0;
        #1;
        check("resume_cmd", out_cmd_r, exec_form(c_b));
        check("resume_src", out_src_r, 1);
        check("resume_vld", out_vld_r, 1);

        // Non-stop opcode on matured path: issued unchanged, sticky error
        c_a = mk_cmd(OP_BUY_LIMIT, 'h77, 55, 3);
        mtr_r = c_a;
        check("err_pre", err_r, 0);
        @(negedge clk);
        #1;
        check("err_cmd", out_cmd_r, c_a);
        check("err_set", err_r, 1);
        mtr_r = mk_cmd(OP_SELL_STOP_LIMIT, 'h78, 56, 4);
        repeat (10) @(negedge clk);
        #1;
        check("err_sticky", err_r, 1);
        check("err_last_cmd", out_cmd_r, exec_form(mtr_r));

        // Asynchronous reset mid-stream
        check("async_pre_vld", out_vld_r, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_vld", out_vld_r, 0);
        check("async_mtr_acc", mtr_accept, 0);
        check("async_err", err_r, 0);
        check("async_cnt", reissue_cnt_r, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        in_vld = 1'b1;
        #1;
        check("post_rst_mtr_acc", mtr_accept, 1);
        check("post_rst_in_acc", in_accept, 0);

        // Randomized traffic against the reference model
        do_reset();
        e_vld = 0; e_cmd = '0; e_src = 0; e_cnt = '0; e_err = 0; e_burst = 0;
        prev_m_go = 1; prev_i_go = 1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!mtr_vld_r || prev_m_go) begin
                mtr_vld_r = ($urandom_range(9) < 6);
                mtr_r     = rand_mtr();
            end
            if (!in_vld || prev_i_go) begin
                in_vld = ($urandom_range(9) < 6);
                in_cmd = mk_cmd(op_t'($urandom_range(9)), $urandom, $urandom, $urandom);
            end
            out_accept = ($urandom_range(9) < 7);
            #1;
            check("rnd_out_vld", out_vld_r, e_vld);
            check("rnd_out_cmd", out_cmd_r, e_cmd);
            check("rnd_out_src", out_src_r, e_src);
            check("rnd_cnt", reissue_cnt_r, e_cnt);
            check("rnd_err", err_r, e_err);
            slot = !e_vld || out_accept;
            m_go = slot && mtr_vld_r && (!in_vld || e_burst < MB);
            i_go = slot && !m_go && in_vld;
            check("rnd_mtr_acc", mtr_accept, m_go);
            check("rnd_in_acc", in_accept, i_go);
            if (m_go) begin
                e_vld = 1; e_cmd = exec_form(mtr_r); e_src = 1; e_cnt = e_cnt + 1'b1;
                if (!is_stop(mtr_r.opcode)) e_err = 1;
            end else if (i_go) begin
                e_vld = 1; e_cmd = in_cmd; e_src = 0;
            end else if (out_accept) begin
                e_vld = 0;
            end
            if (!in_vld || i_go)     e_burst = 0;
            else if (m_go)           e_burst = (e_burst + 1 > MB) ? MB : e_burst + 1;
            prev_m_go = m_go;
            prev_i_go = i_go;
            @(negedge clk);
        end

        // Statistics counter wrap
        do_reset();
        mtr_vld_r  = 1'b1;
        mtr_r      = mk_cmd(OP_BUY_STOP_LOSS, 1, 2, 3);
        out_accept = 1'b1;
        repeat (65535) @(negedge clk);
        #1;
        check("wrap_max", reissue_cnt_r, 16'hFFFF);
        @(negedge clk);
        #1;
        check("wrap_zero", reissue_cnt_r, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ob_cn_reissue.md
# ob_cn_reissue

Consumer end of the conditional-table maturity interface. It accepts matured conditional commands, rewrites each stop opcode to its executable form and merges the result with the external ingress command stream into one registered command output toward the order-book controller. Matured commands take priority over ingress commands. A burst limiter stops matured traffic from starving ingress indefinitely.

## Interface
- `MAX_BURST`, default 4: maximum consecutive matured grants while ingress is waiting; must be ≥1.
- `CNT_W`, default 16: width of the reissue statistics counter.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `mtr_vld_r`  in  1  matured command valid (from conditional table).
- `mtr_r`  in  ob_pkg::cmd_t  matured command.
- `mtr_accept`  out  1  combinational; matured command consumed this cycle.
- `in_vld`  in  1  ingress command valid.
- `in_cmd`  in  ob_pkg::cmd_t  ingress command.
- `in_accept`  out  1  combinational; ingress command consumed this cycle.
- `out_vld_r`  out  1  output command valid (registered).
- `out_cmd_r`  out  ob_pkg::cmd_t  output command (registered).
- `out_src_r`  out  1  1 = output originated from the matured path.
- `out_accept`  in  1  downstream consumes the output this cycle.
- `reissue_cnt_r`  out  CNT_W  count of matured commands accepted; wraps.
- `err_r`  out  1  sticky; a matured command carried a non-stop opcode.

## Operation
- Output slot is free when `!out_vld_r || out_accept`.
- Grant decision, evaluated only when the slot is free:
  - Matured is granted when `mtr_vld_r && (!in_vld || burst_cnt_r < MAX_BURST)`.
  - Otherwise ingress is granted when `in_vld`.
  - Otherwise there is no grant.
- When the slot is not free, `mtr_accept = in_accept = 0`. At most one of the two accepts is high in any cycle.
- Opcode rewrite on the matured path:
  - `OP_BUY_STOP_LIMIT` → `OP_BUY_LIMIT`; `OP_SELL_STOP_LIMIT` → `OP_SELL_LIMIT`.
  - `OP_BUY_STOP_LOSS` → `OP_BUY_MARKET`; `OP_SELL_STOP_LOSS` → `OP_SELL_MARKET`.
  - All other fields (uid, price, quantity) pass unchanged.
  - Any other opcode passes unmodified and sets `err_r`. The command is still issued.
- Ingress commands pass unmodified.
- `burst_cnt_r` (width `$clog2(MAX_BURST+1)`) update rules:
  - Ingress grant → 0.
  - Matured grant while `in_vld` → increment, saturating at `MAX_BURST`.
  - Cycle with `!in_vld` → 0.
- `reissue_cnt_r` increments on every `mtr_accept` and wraps modulo 2^CNT_W.
- `err_r` is cleared only by reset.

## Timing
- Reset values:
  - `out_vld_r = 0`, `out_cmd_r = '0`, `out_src_r = 0`.
  - `reissue_cnt_r = 0`, `err_r = 0`, `burst_cnt_r = 0`.
  - `mtr_accept` and `in_accept` are 0 while reset is asserted.
- Latency: an accepted command appears on `out_vld_r`/`out_cmd_r` in the next cycle.
- Throughput: one command per cycle when `out_accept` is held high.
- Handshake updates:
  - On a grant, `out_vld_r`, `out_cmd_r` and `out_src_r` load next cycle.
  - On `out_accept` with no grant, `out_vld_r` clears.
  - With neither, the output holds stable.
- `out_accept` while `!out_vld_r` is ignored.
- A matured command held on `mtr_vld_r` without accept must remain stable. This block only reads it on grant.
- Simultaneous `out_accept` and grant in the same cycle: the new command replaces the old one with no bubble.
- Mid-operation reset (asynchronous `rst_n` low) clears all state immediately, including a pending output, which is dropped. Release is synchronous to `clk`.

## Test plan
- Reset, then a matured command `OP_BUY_STOP_LIMIT` with uid 0x12 and price 100, `out_accept = 1`:
  - `mtr_accept = 1` at cycle 0.
  - Next cycle `out_vld_r = 1`, opcode `OP_BUY_LIMIT`, uid 0x12, price 100, `out_src_r = 1`, `reissue_cnt_r = 1`.
- `mtr_vld_r` and `in_vld` both held high, `MAX_BURST = 4`, `out_accept = 1`:
  - Grant sequence is M, M, M, M, I, M, M, M, M, I, …
  - `in_accept` pulses every 5th cycle.
- `out_accept = 0` for 3 cycles with the output valid:
  - Both accepts stay 0 and `out_cmd_r` holds.
  - When `out_accept` rises, the next command loads the same cycle, with no bubble.
- Matured command with opcode `OP_BUY_LIMIT`:
  - It is issued unchanged and `err_r` goes to 1.
  - `err_r` stays 1 after 10 further clean commands.
- 65536 matured accepts with `CNT_W = 16`: `reissue_cnt_r` wraps to 0.
- Assert `rst_n` low asynchronously mid-stream while `out_vld_r = 1`:
  - `out_vld_r` drops to 0 without a clock edge.
  - After release, the first grant goes to `mtr_vld_r`.
